// File: rtl/pid_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pid_mc_ctrl
// Brief    : Multi-channel velocity-form PID with one time-shared multiplier,
//            run-time gains and symmetric output clamp with anti-windup.
// Revision : 1.0
// ============================================================================
module pid_mc_ctrl #(
  parameter int W    = 16,
  parameter int NCH  = 4,
  parameter int KW   = 16,
  parameter int FRAC = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [NCH*W-1:0] e_in_i,
  input  logic [KW-1:0]    kp_i,
  input  logic [KW-1:0]    ki_i,
  input  logic [KW-1:0]    kd_i,
  input  logic [W-1:0]     u_max_i,
  output logic             ready_o,
  output logic [NCH*W-1:0] u_out_o,
  output logic             u_valid_o,
  output logic [NCH-1:0]   sat_o
);

  localparam int ACC_W = W + KW + 4;
  localparam int CW    = KW + 2;
  localparam int PW    = CW + W;
  localparam int PAD   = ACC_W - PW;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC0  = 3'd1,
    S_MAC1  = 3'd2,
    S_MAC2  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]         ch_q;
  logic signed [CW-1:0]    k1_q, k2_q, k3_q;
  logic signed [W-1:0]     umax_q;
  logic signed [W-1:0]     e_q     [NCH];
  logic signed [W-1:0]     e1_q    [NCH];
  logic signed [W-1:0]     e2_q    [NCH];
  logic signed [W-1:0]     uprev_q [NCH];
  logic signed [ACC_W-1:0] acc_q;
  logic [NCH*W-1:0]        u_out_q;
  logic [NCH-1:0]          sat_q;

  logic signed [CW-1:0]    kp_s, ki_s, kd_s;
  logic signed [CW-1:0]    coef;
  logic signed [W-1:0]     opnd;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] uprev_ext, umax_ext, umax_neg, sum;
  logic signed [W-1:0]     u_new;
  logic                    sat_new;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i && !clear_i) state_d = S_MAC0;
      S_MAC0:  state_d = S_MAC1;
      S_MAC1:  state_d = S_MAC2;
      S_MAC2:  state_d = S_WRITE;
      S_WRITE: state_d = (ch_q == LAST_CH) ? S_DONE : S_MAC0;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_o   = (state_q == S_IDLE);
  assign u_valid_o = (state_q == S_DONE);
  assign u_out_o   = u_out_q;
  assign sat_o     = sat_q;

  assign kp_s = {{2{kp_i[KW-1]}}, kp_i};
  assign ki_s = {{2{ki_i[KW-1]}}, ki_i};
  assign kd_s = {{2{kd_i[KW-1]}}, kd_i};

  // Shared multiplier: coefficient/history operand chosen by MAC phase.
  always_comb begin
    coef = k1_q;
    opnd = e_q[ch_q];
    if (state_q == S_MAC1) begin
      coef = k2_q;
      opnd = e1_q[ch_q];
    end else if (state_q == S_MAC2) begin
      coef = k3_q;
      opnd = e2_q[ch_q];
    end
  end

  assign prod      = PW'(coef) * PW'(opnd);
  assign prod_ext  = {{PAD{prod[PW-1]}}, prod};
  assign uprev_ext = {{(ACC_W-W){uprev_q[ch_q][W-1]}}, uprev_q[ch_q]};
  assign umax_ext  = {{(ACC_W-W){umax_q[W-1]}}, umax_q};
  assign umax_neg  = -umax_ext;
  assign sum       = (acc_q >>> FRAC) + uprev_ext;

  always_comb begin
    u_new   = sum[W-1:0];
    sat_new = 1'b0;
    if (umax_q[W-1] || (umax_q == '0)) begin
      u_new   = '0;
      sat_new = 1'b1;
    end else if (sum > umax_ext) begin
      u_new   = umax_q;
      sat_new = 1'b1;
    end else if (sum < umax_neg) begin
      u_new   = umax_neg[W-1:0];
      sat_new = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ch_q    <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      umax_q  <= '0;
      acc_q   <= '0;
      u_out_q <= '0;
      sat_q   <= '0;
      for (int c = 0; c < NCH; c++) begin
        e_q[c]     <= '0;
        e1_q[c]    <= '0;
        e2_q[c]    <= '0;
        uprev_q[c] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (clear_i) begin
            for (int c = 0; c < NCH; c++) begin
              e1_q[c]    <= '0;
              e2_q[c]    <= '0;
              uprev_q[c] <= '0;
            end
          end else if (start_i) begin
            k1_q   <= kp_s + ki_s + kd_s;
            k2_q   <= kp_s + (kd_s <<< 1);
            k3_q   <= kd_s;
            umax_q <= u_max_i;
            ch_q   <= '0;
            for (int c = 0; c < NCH; c++) e_q[c] <= e_in_i[c*W +: W];
          end
        end
        S_MAC0: acc_q <= prod_ext;
        S_MAC1: acc_q <= acc_q - prod_ext;
        S_MAC2: acc_q <= acc_q + prod_ext;
        S_WRITE: begin
          // Clamped value becomes the new history, which is what prevents windup.
          u_out_q[ch_q*W +: W] <= u_new;
          uprev_q[ch_q]        <= u_new;
          sat_q[ch_q]          <= sat_new;
          e2_q[ch_q]           <= e1_q[ch_q];
          e1_q[ch_q]           <= e_q[ch_q];
          ch_q                 <= ch_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
